// File: rtl/nr_fxp_reciprocal_seq.sv
// nr_fxp_reciprocal_seq
//   Sequential Newton-Raphson reciprocal. Takes an unsigned fixed-point [4:-19] operand d and
//   returns the 16-bit unsigned integer round(1/d). One 24x24 multiplier is shared by every
//   multiply state. Zero, or 1/d >= 65535.5, saturates to 0xFFFF with sat_o set.
//
//   Optional feature: define NR_POW2_BYPASS_EN so that single-bit operands skip the iteration
//   and finish one cycle after accept.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operand valid
//   in_ready_o   idle, operand can be accepted
//   in0_i        operand d, unsigned [4:-19]
//   out_valid_o  result valid, held until out_ready_i
//   out_ready_i  consumer accepts the result
//   out0_o       unsigned integer result
//   sat_o        result saturated
module nr_fxp_reciprocal_seq #(
  parameter int unsigned MAX_ITER = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [23:0] in0_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out0_o,
  output logic        sat_o
);

  localparam logic [23:0] ConstA    = 24'h0F0F0D;
  localparam logic [23:0] ConstB    = 24'h169696;
  localparam logic [23:0] ConstHalf = 24'h040000;
  localparam logic [23:0] ConstOne  = 24'h080000;
  localparam logic [23:0] ConstTwo  = 24'h100000;

  typedef enum logic [3:0] {
    StIdle, StCompScale, StMulA, StSubB, StMulScaled, StSub2, StMulNew, StCheckEq,
    StAssignNew, StDenorm, StDone
  } state_e;

  state_e             state_q;
  logic [23:0]        scaled_q, x_q, t_q;
  logic signed [5:0]  k_q;          // scaled = d * 2^k
  logic [3:0]         iter_q;
  logic               force_sat_q;
  logic               in_ready_q, out_valid_q, sat_q;
  logic [15:0]        out0_q;

  // Shared multiplier, result re-aligned to [4:-19] by truncation.
  logic [23:0] mul_a, mul_b, mul_res;
  logic [47:0] mul_p;

  always_comb begin
    mul_a = x_q;
    mul_b = t_q;
    if (state_q == StMulA) begin
      mul_a = scaled_q;
      mul_b = ConstA;
    end else if (state_q == StMulScaled) begin
      mul_b = scaled_q;
    end
    mul_p   = 48'(mul_a) * 48'(mul_b);
    mul_res = 24'(mul_p >> 19);
  end

  // 1/d = x * 2^k, then round half-up to an integer.
  logic [5:0]  k_mag;
  logic [42:0] denorm_r;
  logic [23:0] denorm_rnd;

  always_comb begin
    k_mag      = k_q[5] ? 6'(-k_q) : 6'(k_q);
    denorm_r   = k_q[5] ? ({19'd0, x_q} >> k_mag) : ({19'd0, x_q} << k_mag);
    denorm_rnd = 24'((denorm_r + 43'h40000) >> 19);
  end

`ifdef NR_POW2_BYPASS_EN
  logic        pow2_hit;
  logic        pow2_sat;
  logic [15:0] pow2_val;

  // Bit p set means d = 2^(p-19); bits 0..3 give 1/d >= 2^16, which saturates.
  always_comb begin
    pow2_hit = (in0_i != '0) && ((in0_i & (in0_i - 24'd1)) == '0);
    pow2_sat = |in0_i[3:0];
    pow2_val = 16'hFFFF;
    if (!pow2_sat) begin
      pow2_val = '0;
      for (int p = 4; p < 24; p++) begin
        if (in0_i[p]) pow2_val = 16'((ConstOne + (24'd1 << (p - 1))) >> p);
      end
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      scaled_q    <= '0;
      x_q         <= '0;
      t_q         <= '0;
      k_q         <= '0;
      iter_q      <= '0;
      force_sat_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out0_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            scaled_q    <= in0_i;
            k_q         <= '0;
            iter_q      <= '0;
            force_sat_q <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef NR_POW2_BYPASS_EN
            if (pow2_hit) begin
              out0_q      <= pow2_val;
              sat_q       <= pow2_sat;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else
`endif
            if (in0_i == '0) begin
              force_sat_q <= 1'b1;
              state_q     <= StDenorm;
            end else begin
              state_q <= StCompScale;
            end
          end
        end
        StCompScale: begin
          if (scaled_q < ConstHalf) begin
            scaled_q <= scaled_q << 1;
            k_q      <= k_q + 6'sd1;
          end else if (scaled_q >= ConstOne) begin
            scaled_q <= scaled_q >> 1;
            k_q      <= k_q - 6'sd1;
          end else begin
            state_q <= StMulA;
          end
        end
        StMulA: begin
          x_q     <= mul_res;
          state_q <= StSubB;
        end
        StSubB: begin
          x_q     <= ConstB - x_q;
          state_q <= StMulScaled;
        end
        StMulScaled: begin
          t_q     <= mul_res;
          state_q <= StSub2;
        end
        StSub2: begin
          t_q     <= ConstTwo - t_q;
          state_q <= StMulNew;
        end
        StMulNew: begin
          t_q     <= mul_res;
          iter_q  <= iter_q + 4'd1;
          state_q <= StCheckEq;
        end
        StCheckEq: begin
          if ((t_q == x_q) || (iter_q == 4'(MAX_ITER))) state_q <= StDenorm;
          else                                          state_q <= StAssignNew;
        end
        StAssignNew: begin
          x_q     <= t_q;
          state_q <= StMulScaled;
        end
        StDenorm: begin
          if (force_sat_q || (denorm_rnd > 24'h00FFFF)) begin
            out0_q <= 16'hFFFF;
            sat_q  <= 1'b1;
          end else begin
            out0_q <= denorm_rnd[15:0];
            sat_q  <= 1'b0;
          end
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out0_o      = out0_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_nr_fxp_reciprocal_seq.sv
// Directed testbench for nr_fxp_reciprocal_seq: a table of operands with hand-computed
// reciprocal ranges, plus sequences for latency, backpressure and mid-operation reset.
module tb_nr_fxp_reciprocal_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out0;
  logic        sat;

  int checks = 0;
  int errors = 0;

  nr_fxp_reciprocal_seq #(.MAX_ITER(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in0_i      (in0),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out0_o     (out0),
    .sat_o      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        s;
  } vec_t;

  vec_t vecs[$];

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input logic [31:0] act, input logic [31:0] lo,
                           input logic [31:0] hi);
    checks++;
    if ((act < lo) || (act > hi) || $isunknown(act)) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h..%0h", name, act, lo, hi);
    end
  endtask

  // Presents d for one accept edge and waits for out_valid. Latency counts the accept cycle
  // as cycle 1 (so a result visible right after the accept edge has latency 1).
  task automatic do_op(input logic [23:0] d, output logic [15:0] r, output logic s,
                       output int lat);
    in0      = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk_eq("timeout", 32'(out_valid), 32'd1);
    r = out0;
    s = sat;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  logic [15:0] r;
  logic        s;
  int          lat;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in0       = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk_eq("rst_in_ready", 32'(in_ready), 32'd1);
    chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_out0", 32'(out0), 32'd0);
    chk_eq("rst_sat", 32'(sat), 32'd0);

    // d, lowest and highest acceptable out0, expected sat
    vecs.push_back('{24'h080000, 16'd1, 16'd1, 1'b0});          // 1.0
    vecs.push_back('{24'h008000, 16'd16, 16'd16, 1'b0});        // 1/16
    vecs.push_back('{24'h0C0000, 16'd1, 16'd1, 1'b0});          // 1.5 -> 0.667
    vecs.push_back('{24'h180000, 16'd0, 16'd0, 1'b0});          // 3.0 -> 0.333
    vecs.push_back('{24'h000D1B, 16'd156, 16'd158, 1'b0});      // ~1/156.27
    vecs.push_back('{24'h000000, 16'hFFFF, 16'hFFFF, 1'b1});    // zero
    vecs.push_back('{24'h000007, 16'hFFFF, 16'hFFFF, 1'b1});    // 1/d = 74898
    vecs.push_back('{24'h040000, 16'd2, 16'd2, 1'b0});          // 0.5
    vecs.push_back('{24'h000001, 16'hFFFF, 16'hFFFF, 1'b1});    // 1/d = 2^19
    vecs.push_back('{24'h000008, 16'hFFFF, 16'hFFFF, 1'b1});    // 1/d = 65536
    vecs.push_back('{24'h000010, 16'd32768, 16'd32768, 1'b0});  // 1/d = 32768
    vecs.push_back('{24'h000009, 16'd58253, 16'd58255, 1'b0});  // 58254.2, just below sat
    vecs.push_back('{24'h800000, 16'd0, 16'd0, 1'b0});          // 16.0, largest right shift
    vecs.push_back('{24'hFFFFFF, 16'd0, 16'd0, 1'b0});          // ~32
    vecs.push_back('{24'h020000, 16'd4, 16'd4, 1'b0});          // 0.25
    vecs.push_back('{24'h01999A, 16'd4, 16'd6, 1'b0});          // ~0.2
    vecs.push_back('{24'h02AAAB, 16'd2, 16'd4, 1'b0});          // ~1/3

    foreach (vecs[i]) begin
      do_op(vecs[i].d, r, s, lat);
      chk_range($sformatf("out0[%0h]", vecs[i].d), 32'(r), 32'(vecs[i].lo), 32'(vecs[i].hi));
      chk_eq($sformatf("sat[%0h]", vecs[i].d), 32'(s), 32'(vecs[i].s));
      finish_op();
    end

    // Zero operand: accept cycle, DENORM, then DONE.
    do_op(24'h000000, r, s, lat);
    chk_eq("lat_zero", 32'(lat), 32'd2);
    finish_op();

`ifdef NR_POW2_BYPASS_EN
    do_op(24'h008000, r, s, lat);
    chk_eq("lat_bypass", 32'(lat), 32'd1);
    chk_eq("bypass_out0", 32'(r), 32'd16);
    finish_op();
`else
    // 1.0 normalizes with one shift: latency = 1 + (1+1) + 2 + 5I - 1 + 1 = 5I + 5, I in 1..8.
    do_op(24'h080000, r, s, lat);
    checks++;
    if ((lat % 5 != 0) || (lat < 10) || (lat > 45)) begin
      errors++;
      $display("FAIL lat_one actual=%0d required=5*I+5 with I in 1..8", lat);
    end
    finish_op();
`endif

    // Backpressure: result and handshake signals hold while out_ready is low.
    do_op(24'h0C0000, r, s, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk_eq("bp_out0", 32'(out0), 32'd1);
      chk_eq("bp_in_ready", 32'(in_ready), 32'd0);
      chk_eq("bp_out_valid", 32'(out_valid), 32'd1);
    end
    finish_op();
    chk_eq("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk_eq("bp_release_out_valid", 32'(out_valid), 32'd0);
    do_op(24'h008000, r, s, lat);
    chk_eq("b2b_out0", 32'(r), 32'd16);
    finish_op();

    // out_ready already high when the result appears: handshake completes in that cycle.
    out_ready = 1'b1;
    do_op(24'h020000, r, s, lat);
    chk_eq("rdy_high_out0", 32'(r), 32'd4);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk_eq("rdy_high_in_ready", 32'(in_ready), 32'd1);
    chk_eq("rdy_high_out_valid", 32'(out_valid), 32'd0);

    // Reset during MUL_NEW: for 1.0 the states after accept are COMP x2, MUL_A, SUB_B,
    // MUL_SCALED, SUB_2, so six edges after the accept edge the FSM sits in MUL_NEW.
    in0      = 24'h080000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk_eq("pre_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (60) @(posedge clk);
    #1;
    chk_eq("mid_rst_discarded", 32'(out_valid), 32'd0);
    do_op(24'h040000, r, s, lat);
    chk_eq("post_rst_out0", 32'(r), 32'd2);
    chk_eq("post_rst_sat", 32'(s), 32'd0);
    finish_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
